// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes,
// mux-select and ALU encodings.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JALR,
        S_JAL,
        S_BRANCH,
        S_LUI,
        S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'd0;
    localparam logic [1:0] RES_DATA      = 2'd1;
    localparam logic [1:0] RES_ALURESULT = 2'd2;
    localparam logic [1:0] RES_IMMEXT    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_A     = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_IMMEXT = 2'd1;
    localparam logic [1:0] SRCB_FOUR   = 2'd2;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_BRANCH,
        ALUOP_FUNCT
    } alu_op_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode: (ALUOp, funct3, funct7[5]) -> ALUControl, plus the
// branch-taken condition evaluated against the ALU Zero flag.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    output logic [2:0] alu_control,
    output logic       taken
);

    always_comb begin
        alu_control = ALU_ADD;
        taken       = 1'b0;
        case (alu_op)
            ALUOP_BRANCH: begin
                // blt/bge rely on slt: result 1 (non-zero) means less-than
                case (funct3)
                    3'b000:  begin alu_control = ALU_SUB; taken = zero;  end
                    3'b001:  begin alu_control = ALU_SUB; taken = !zero; end
                    3'b100:  begin alu_control = ALU_SLT; taken = !zero; end
                    3'b101:  begin alu_control = ALU_SLT; taken = zero;  end
                    default: begin alu_control = ALU_SUB; taken = 1'b0;  end
                endcase
            end
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  alu_control = ALU_AND;
                    3'b110:  alu_control = ALU_OR;
                    3'b100:  alu_control = ALU_XOR;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath.
// Optional macro ILLEGAL_TRAP_EN: unknown opcodes park the FSM in HALT until reset.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       halt
);

    state_t  state, next_state;
    alu_op_t alu_op;
    logic    pc_update, branch, mem_write, ir_write, reg_write, taken;
    logic    unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_ff @(posedge clk) begin
        if (!rst) state <= S_FETCH;
        else      state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_LUI:            next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:           next_state = S_HALT;
`else
                    default:           next_state = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  next_state = S_MEMWB;
            S_EXECR,
            S_EXECI:    next_state = S_ALUWB;
            S_JALR:     next_state = S_JAL;
            S_JAL:      next_state = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     next_state = S_HALT;
`endif
            default:    next_state = S_FETCH;
        endcase
    end

    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_B;
        alu_op    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMMEXT;
            end
            S_MEMADR, S_EXECI, S_JALR: begin
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMMEXT;
                if (state == S_EXECI) alu_op = ALUOP_FUNCT;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                pc_update = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                alu_op  = ALUOP_BRANCH;
                branch  = 1'b1;
            end
            S_LUI: begin
                ResultSrc = RES_IMMEXT;
                reg_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = IMM_S;
            OP_BRANCH: ImmSrc = IMM_B;
            OP_JAL:    ImmSrc = IMM_J;
            OP_LUI:    ImmSrc = IMM_U;
            default:   ImmSrc = IMM_I;
        endcase
    end

    // funct7[5] selects sub only for R-type; op[5] separates R from I encodings
    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7[5] & op[5]),
        .zero        (Zero),
        .alu_control (ALUControl),
        .taken       (taken)
    );

    // Enables are gated by rst so nothing writes while reset is held
    assign PCWrite  = rst & (pc_update | (branch & taken));
    assign MemWrite = rst & mem_write;
    assign IRWrite  = rst & ir_write;
    assign RegWrite = rst & reg_write;
`ifdef ILLEGAL_TRAP_EN
    assign halt     = rst & (state == S_HALT);
`else
    assign halt     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench: randomized instruction stream against a per-instruction
// table of expected control vectors, plus directed reset/illegal-op cases.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, halt;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;

    int errors = 0;
    int checks = 0;

    multicycle_controller #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .halt(halt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pcw;
        logic       br;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       hlt;
        string      name;
    } step_t;

    step_t plan[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic step_t mk(input string name, input logic pcw, input logic br,
                                 input logic adr, input logic mw, input logic irw,
                                 input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                                 input logic [1:0] sb, input logic [2:0] alu, input logic hlt);
        step_t s;
        s.name = name; s.pcw = pcw; s.br = br; s.adr = adr; s.mw = mw; s.irw = irw;
        s.rw = rw; s.rs = rs; s.sa = sa; s.sb = sb; s.alu = alu; s.hlt = hlt;
        return s;
    endfunction

    function automatic logic [2:0] ref_imm(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic is_r, input logic f7b5);
        case (f3)
            3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b011:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return !z;
            3'b101:  return z;
            default: return 1'b0;
        endcase
    endfunction

    // Builds the expected cycle sequence of one instruction from its class
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        logic [2:0] br_alu;
        br_alu = (f3 == 3'b100 || f3 == 3'b101) ? 3'b101 : 3'b001;
        plan.delete();
        plan.push_back(mk("fetch",  1,0,0,0,1,0, 2,0,2, 0, 0));
        plan.push_back(mk("decode", 0,0,0,0,0,0, 0,1,1, 0, 0));
        case (o)
            7'b0000011: begin
                plan.push_back(mk("memadr",  0,0,0,0,0,0, 0,2,1, 0, 0));
                plan.push_back(mk("memread", 0,0,1,0,0,0, 0,0,0, 0, 0));
                plan.push_back(mk("memwb",   0,0,0,0,0,1, 1,0,0, 0, 0));
            end
            7'b0100011: begin
                plan.push_back(mk("memadr",  0,0,0,0,0,0, 0,2,1, 0, 0));
                plan.push_back(mk("memwr",   0,0,1,1,0,0, 0,0,0, 0, 0));
            end
            7'b0110011: begin
                plan.push_back(mk("execr", 0,0,0,0,0,0, 0,2,0, ref_alu(f3, 1, f7[5]), 0));
                plan.push_back(mk("aluwb", 0,0,0,0,0,1, 0,0,0, 0, 0));
            end
            7'b0010011: begin
                plan.push_back(mk("execi", 0,0,0,0,0,0, 0,2,1, ref_alu(f3, 0, f7[5]), 0));
                plan.push_back(mk("aluwb", 0,0,0,0,0,1, 0,0,0, 0, 0));
            end
            7'b1100111, 7'b1101111: begin
                if (o == 7'b1100111)
                    plan.push_back(mk("jalr", 0,0,0,0,0,0, 0,2,1, 0, 0));
                plan.push_back(mk("jal",   1,0,0,0,0,0, 0,1,2, 0, 0));
                plan.push_back(mk("aluwb", 0,0,0,0,0,1, 0,0,0, 0, 0));
            end
            7'b1100011: plan.push_back(mk("branch", 0,1,0,0,0,0, 0,2,0, br_alu, 0));
            7'b0110111: plan.push_back(mk("lui",    0,0,0,0,0,1, 3,0,0, 0, 0));
            default: begin
`ifdef ILLEGAL_TRAP_EN
                for (int i = 0; i < 10; i++)
                    plan.push_back(mk("halt", 0,0,0,0,0,0, 0,0,0, 0, 1));
`endif
            end
        endcase
    endtask

    // Entered and left at 1 time unit after a rising edge
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        logic pcw;
        logic [17:0] got, exp;
        build(o, f3, f7);
        op = o; funct3 = f3; funct7 = f7;
        foreach (plan[i]) begin
            Zero = 1'($urandom);
            pcw  = plan[i].pcw | (plan[i].br & ref_taken(f3, Zero));
            exp  = {pcw, plan[i].adr, plan[i].mw, plan[i].irw, plan[i].rw, plan[i].rs,
                    plan[i].sa, plan[i].sb, plan[i].alu, ref_imm(o), plan[i].hlt};
            @(negedge clk);
            got  = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                    ALUSrcA, ALUSrcB, ALUControl, ImmSrc, halt};
            check($sformatf("%s op=%b f3=%b z=%b", plan[i].name, o, f3, Zero), 32'(got), 32'(exp));
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check("reset_enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite, halt}), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    localparam int N_OPS = 11;
    logic [6:0] op_tbl [N_OPS] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                   7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111,
                                   7'b1111111, 7'b0000000, 7'b0010111};
    logic [2:0] br_tbl [4] = '{3'b000, 3'b001, 3'b100, 3'b101};

    initial begin
        logic [6:0] o;
        logic [2:0] f3;
        rst = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; Zero = 1'b0;
        #1;
        do_reset(2);

        // directed: sub, lw, bne both ways, jalr, lui
        run_instr(7'b0110011, 3'b000, 7'b0100000);
        run_instr(7'b0000011, 3'b010, 7'b0000000);
        run_instr(7'b1100011, 3'b001, 7'b0000000);
        run_instr(7'b1100011, 3'b001, 7'b0000000);
        run_instr(7'b1100111, 3'b000, 7'b0000000);
        run_instr(7'b0110111, 3'b000, 7'b0000000);
        run_instr(7'b0010011, 3'b000, 7'b0100000);

        // reset asserted in MEMWB of a load must suppress RegWrite
        op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0;
        repeat (4) @(posedge clk);
        #1;
        do_reset(1);
        run_instr(7'b0100011, 3'b010, 7'b0000000);

        // illegal op
        run_instr(7'b1111111, 3'b000, 7'b0000000);
`ifdef ILLEGAL_TRAP_EN
        do_reset(1);
`endif
        run_instr(7'b0110011, 3'b111, 7'b0000000);

        for (int n = 0; n < 300; n++) begin
            o  = op_tbl[$urandom_range(N_OPS - 1)];
            f3 = (o == 7'b1100011) ? br_tbl[$urandom_range(3)] : 3'($urandom);
            run_instr(o, f3, 7'($urandom));
`ifdef ILLEGAL_TRAP_EN
            if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                            7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111}))
                do_reset(1);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
